// File: rtl/image_blur.sv
// image_blur: frame-buffered 3x3 box blur for interleaved 8-bit RGB.
//
// It captures one WIDTH x HEIGHT frame (3 bytes per pixel, R/G/B) into an input
// buffer. It then computes a per-channel 3x3 mean with edge-replicated borders
// into an output buffer, and finally streams the result out at one byte per clock.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-low reset
//   start     - frame-start request, honoured only when idle
//   image_in  - input byte stream (captured during LOAD)
//   image_out - output byte stream (registered, 0x00 when not presenting)
//   done      - high while the blurred frame is being presented
module image_blur #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] image_in,
    output logic [7:0] image_out,
    output logic       done
);

    localparam int unsigned N    = WIDTH * HEIGHT * 3;
    localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW   = $clog2(N + 2);
    localparam int unsigned XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW   = $clog2(HEIGHT + 1);
    localparam int          HMax = int'(HEIGHT) - 1;
    localparam int          WMax = int'(WIDTH) - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StOutput} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;          // byte index for load / compute
    logic [YW-1:0]   row_q, row_d;          // pixel position of idx_q
    logic [XW-1:0]   col_q, col_d;
    logic [1:0]      chan_q, chan_d;
    logic [1:0]      wr_q, wr_d;            // window row/col offset, 0..2
    logic [1:0]      wc_q, wc_d;
    logic [11:0]     acc_q, acc_d;          // partial window sum
    logic [CW-1:0]   out_cnt_q, out_cnt_d;  // cycles spent in OUTPUT
    logic            done_q, done_d;
    logic [7:0]      image_out_q, image_out_d;

    logic [7:0]      ibuf [N];
    logic [7:0]      obuf [N];
    logic            ibuf_we, obuf_we;

    int              rr, cc;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_byte;
    logic [11:0]     sum;
    logic [23:0]     prod;
    logic [7:0]      blur_byte;
    logic [7:0]      out_byte;

    // Window tap address with clamping to the frame (edge replication).
    always_comb begin
        rr = int'(row_q) + int'(wr_q) - 1;
        cc = int'(col_q) + int'(wc_q) - 1;
        if (rr < 0) rr = 0;
        else if (rr > HMax) rr = HMax;
        if (cc < 0) cc = 0;
        else if (cc > WMax) cc = WMax;
        rd_addr = AW'((rr * int'(WIDTH) + cc) * 3 + int'(chan_q));
    end

    assign rd_byte   = ibuf[rd_addr];
    assign sum       = acc_q + 12'(rd_byte);
    // Multiply by 7282 and shift by 16: this equals floor(sum/9) exactly for sum <= 2295.
    assign prod      = 24'(sum) * 24'd7282;
    assign blur_byte = 8'(prod >> 16);
    assign out_byte  = obuf[AW'(out_cnt_q - CW'(1))];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        chan_d      = chan_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        acc_d       = acc_q;
        out_cnt_d   = out_cnt_q;
        image_out_d = 8'h00;
        ibuf_we     = 1'b0;
        obuf_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                ibuf_we = 1'b1;
                if (idx_q == AW'(N - 1)) begin
                    state_d = StCompute;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    chan_d  = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    acc_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            StCompute: begin
                // One tap per cycle; the ninth tap completes the sum and writes the result.
                if (wr_q == 2'd2 && wc_q == 2'd2) begin
                    obuf_we = 1'b1;
                    acc_d   = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    if (chan_q == 2'd2) begin
                        chan_d = '0;
                        if (col_q == XW'(WIDTH - 1)) begin
                            col_d = '0;
                            row_d = row_q + YW'(1);
                        end else begin
                            col_d = col_q + XW'(1);
                        end
                    end else begin
                        chan_d = chan_q + 2'd1;
                    end
                    if (idx_q == AW'(N - 1)) begin
                        state_d   = StOutput;
                        out_cnt_d = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    acc_d = sum;
                    if (wc_q == 2'd2) begin
                        wc_d = '0;
                        wr_d = wr_q + 2'd1;
                    end else begin
                        wc_d = wc_q + 2'd1;
                    end
                end
            end
            StOutput: begin
                // Count 0 is the idle gap cycle; counts 1..N present bytes 0..N-1.
                if (out_cnt_q == CW'(N + 1)) begin
                    state_d   = StIdle;
                    out_cnt_d = '0;
                end else begin
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q != '0) image_out_d = out_byte;
                end
            end
            default: state_d = StIdle;
        endcase

        done_d = (state_d == StOutput);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            chan_q      <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            acc_q       <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
            image_out_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chan_q      <= chan_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            acc_q       <= acc_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
            image_out_q <= image_out_d;
        end
    end

    // Frame buffers carry no reset; their contents are rewritten every frame.
    always_ff @(posedge clk) begin
        if (ibuf_we) ibuf[idx_q] <= image_in;
        if (obuf_we) obuf[idx_q] <= blur_byte;
    end

    assign image_out = image_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_image_blur.sv
// tb_image_blur: directed self-checking bench for image_blur (20x12 RGB).
// Each frame is loaded, then every output byte is checked against a hand-derived
// expected frame together with the done/image_out alignment around the output window.
module tb_image_blur;

    localparam int W = 20;
    localparam int H = 12;
    localparam int N = W * H * 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] image_in;
    logic [7:0] image_out;
    logic       done;

    logic [7:0] frame_in  [N];
    logic [7:0] frame_exp [N];

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int rise_cnt   = 0;
    logic done_prev = 1'b0;
    int frame_no   = 0;

    image_blur #(.WIDTH(W), .HEIGHT(H)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .image_in  (image_in),
        .image_out (image_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of done, sampled away from the active edge.
    always @(negedge clk) begin
        if (done && !done_prev) rise_cnt <= rise_cnt + 1;
        done_prev <= done;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bidx(input int row, input int col, input int ch);
        return (row * W + col) * 3 + ch;
    endfunction

    task automatic fill_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int i = 0; i < N; i++) begin
            frame_in[i]  = (i % 3 == 0) ? r : ((i % 3 == 1) ? g : b);
            frame_exp[i] = frame_in[i];
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < N; i++) begin
            frame_in[i]  = 8'h00;
            frame_exp[i] = 8'h00;
        end
    endtask

    // Loads frame_in, waits for done and checks the whole output window.
    // abort_after > 0 pulses reset after that many output bytes have been checked.
    task automatic run_frame(input bit hold_start, input int abort_after);
        int    n;
        int    rise_before;
        string tag;
        frame_no++;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        for (int i = 0; i < N; i++) begin
            image_in = frame_in[i];
            tick();
        end
        check_val($sformatf("f%0d_done_low_after_load", frame_no), {31'b0, done}, 32'd0);
        rise_before = rise_cnt;
        n = 0;
        while (!done && n < 10 * N + 4) begin
            tick();
            n++;
        end
        if (!done) begin
            check_val($sformatf("f%0d_done_timeout", frame_no), {31'b0, done}, 32'd1);
            start = 1'b0;
            return;
        end
        check_val($sformatf("f%0d_out_zero_at_D", frame_no), {24'b0, image_out}, 32'd0);
        tick();
        check_val($sformatf("f%0d_out_zero_at_D1", frame_no), {24'b0, image_out}, 32'd0);
        check_val($sformatf("f%0d_done_at_D1", frame_no), {31'b0, done}, 32'd1);
        for (int k = 0; k < N; k++) begin
            tick();
            tag = $sformatf("f%0d_byte%0d", frame_no, k);
            check_val(tag, {24'b0, image_out}, {24'b0, frame_exp[k]});
            if (k == N - 1)
                check_val($sformatf("f%0d_done_last_byte", frame_no), {31'b0, done}, 32'd1);
            if (abort_after > 0 && k + 1 == abort_after) begin
                #2 reset = 1'b0;
                #1;
                check_val($sformatf("f%0d_rst_done", frame_no), {31'b0, done}, 32'd0);
                check_val($sformatf("f%0d_rst_out", frame_no), {24'b0, image_out}, 32'd0);
                start = 1'b0;
                tick();
                reset = 1'b1;
                return;
            end
        end
        tick();
        check_val($sformatf("f%0d_done_fall", frame_no), {31'b0, done}, 32'd0);
        check_val($sformatf("f%0d_out_zero_after", frame_no), {24'b0, image_out}, 32'd0);
        check_val($sformatf("f%0d_done_rises", frame_no), rise_cnt - rise_before, 32'd1);
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        image_in = 8'h00;
        tick();
        tick();
        check_val("reset_done", {31'b0, done}, 32'd0);
        check_val("reset_out", {24'b0, image_out}, 32'd0);
        reset = 1'b1;
        tick();

        // Uniform mid-grey.
        fill_rgb(8'h80, 8'h80, 8'h80);
        run_frame(1'b0, 0);

        // Interior impulse on R at (5,10).
        fill_zero();
        frame_in[bidx(5, 10, 0)] = 8'hFF;
        for (int r = 4; r <= 6; r++)
            for (int c = 9; c <= 11; c++) frame_exp[bidx(r, c, 0)] = 8'h1C;
        run_frame(1'b0, 0);

        // Top-left corner impulse on R.
        fill_zero();
        frame_in[bidx(0, 0, 0)]  = 8'hFF;
        frame_exp[bidx(0, 0, 0)] = 8'h71;
        frame_exp[bidx(0, 1, 0)] = 8'h38;
        frame_exp[bidx(1, 0, 0)] = 8'h38;
        frame_exp[bidx(1, 1, 0)] = 8'h1C;
        run_frame(1'b0, 0);

        // Bottom-right corner impulse on B.
        fill_zero();
        frame_in[bidx(11, 19, 2)]  = 8'hFF;
        frame_exp[bidx(11, 19, 2)] = 8'h71;
        frame_exp[bidx(11, 18, 2)] = 8'h38;
        frame_exp[bidx(10, 19, 2)] = 8'h38;
        frame_exp[bidx(10, 18, 2)] = 8'h1C;
        run_frame(1'b0, 0);

        // Saturated frame: largest sum through the divider.
        fill_rgb(8'hFF, 8'hFF, 8'hFF);
        run_frame(1'b0, 0);

        // Per-channel constants, reset pulsed part-way through the output stream.
        fill_rgb(8'h10, 8'h20, 8'h30);
        run_frame(1'b0, 30);

        // Reset during LOAD, after byte 100 has been captured.
        fill_rgb(8'hFF, 8'hFF, 8'hFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            image_in = frame_in[i];
            tick();
        end
        #2 reset = 1'b0;
        #1;
        check_val("midload_rst_done", {31'b0, done}, 32'd0);
        check_val("midload_rst_out", {24'b0, image_out}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Fresh frame after reset: left-edge impulse on G at (3,0).
        fill_zero();
        frame_in[bidx(3, 0, 1)] = 8'hFF;
        for (int r = 2; r <= 4; r++) begin
            frame_exp[bidx(r, 0, 1)] = 8'h38;
            frame_exp[bidx(r, 1, 1)] = 8'h1C;
        end
        run_frame(1'b0, 0);

        // Back-to-back distinct frame with start held through LOAD and OUTPUT.
        fill_rgb(8'h10, 8'h20, 8'h30);
        run_frame(1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/image_blur.md
# image_blur

Frame-buffered 3×3 box-blur engine for interleaved 8-bit RGB images. It streams in one WIDTH×HEIGHT frame at one byte per clock and computes a per-channel 3×3 mean with edge-replicated borders. It then raises `done` and streams the blurred frame out at one byte per clock. It sits between a byte-serial pixel source and a byte-serial sink in the image-processing pipeline.

## Interface
- `WIDTH`, default 20: image width in pixels.
- `HEIGHT`, default 12: image height in pixels.
- Derived: N = WIDTH·HEIGHT·3 bytes per frame.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  frame-start request, sampled in IDLE only.
- `image_in`  input  8  input byte stream.
- `image_out`  output  8  output byte stream.
- `done`  output  1  high while the blurred frame is being presented.

## Operation
- Byte order for both input and output streams:
  - Byte index i → pixel p = i/3, channel c = i%3 (0=R, 1=G, 2=B).
  - Pixel position: row = p/WIDTH, col = p%WIDTH, row-major.
- Storage: one N-byte input buffer and one N-byte output buffer.
- States and transitions:
  - IDLE → LOAD on a rising edge with `start`=1. That edge captures nothing.
  - LOAD: the next N rising edges capture bytes 0..N-1 of `image_in` into the input buffer. `start` is ignored.
  - LOAD → COMPUTE after byte N-1 is captured.
  - COMPUTE: for every byte index, output = floor(S/9). S is the sum of the same channel over the 3×3 window centred on (row, col).
  - Out-of-range window coordinates are clamped to [0,HEIGHT-1] and [0,WIDTH-1] (edge replication).
  - S is 12 bits wide (max 2295). Division must be exact; (S·7282)>>16 is exact over this range.
  - COMPUTE → OUTPUT when all N results are written.
  - OUTPUT: `done`=1 and the output buffer is streamed out.
  - OUTPUT → IDLE after byte N-1 has been presented for one cycle. `done` drops on that transition.
- `start` outside IDLE has no effect. A new frame needs `start` sampled high in IDLE.
- Reset (any time, including mid-LOAD, COMPUTE or OUTPUT):
  - State goes to IDLE, `done`=0, `image_out`=0x00, counters are cleared.
  - Buffer contents are don't-care.

## Timing
- Reset values: `done`=0, `image_out`=0x00.
- Input: with the start edge called edge S0, byte i is sampled at edge S0+1+i.
- COMPUTE latency must not exceed 10·N cycles.
- Output alignment, with D = the edge on which `done` rises:
  - `image_out` stays 0x00 through edges D and D+1.
  - Byte k appears after edge D+2+k and holds for one cycle, for k = 0..N-1.
  - `done` stays high through the cycle following edge D+1+N, then falls at the next edge.
- All outputs are registered.
- Throughput: one byte per cycle in, one byte per cycle out, with no backpressure.

## Test plan
- Uniform frame, every byte 0x80 → all N output bytes 0x80. `done` rises exactly once; byte 0 appears two edges after `done` rises.
- Impulse: R of pixel (5,10) = 0xFF, all else 0x00 → R = 0x1C at the 9 pixels rows 4–6 × cols 9–11. All other bytes, and every G and B byte, = 0x00.
- Corner impulse: R of pixel (0,0) = 0xFF, all else 0x00 → R at (0,0) = 0x71; R at (0,1) and (1,0) = 0x38; R at (1,1) = 0x1C; everything else 0x00.
- All-0xFF frame → all 0xFF, with no overflow in the sum or divider.
- Reset pulsed mid-LOAD (after byte 100) → `done`=0 and `image_out`=0x00 immediately. A subsequent full frame after `start` blurs correctly with no residue.
- Back-to-back frames: after `done` falls, assert `start` and load a second distinct frame → second output is correct. `start` held high during LOAD and OUTPUT has no effect.
